// File: rtl/nvdla_ssync_req_arb.sv
// Round-robin arbiter that shares one strict 3-flop synchronizer channel among NUM_REQ sources,
// holding sync_id quasi-static and running a 4-phase handshake. Optional timeout: NVDLA_SSYNC_ARB_TIMEOUT_EN.
module nvdla_ssync_req_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TMO_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_done,
  output logic [ID_W-1:0]    sync_id,
  output logic               sync_req,
  input  logic               ack_sync,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [1:0] {IDLE, SETUP, REQ, REL} state_t;

  state_t             state_reg, state_next;
  logic [ID_W-1:0]    ptr_reg, ptr_next;
  logic [ID_W-1:0]    id_reg, id_next;
  logic               sync_req_reg, sync_req_next;
  logic               busy_reg, busy_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic               done_fire;
  logic               tmo_hit;
  logic [ID_W-1:0]    winner;

  // Nearest requester after ptr; iterating from farthest to nearest lets the nearest overwrite.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0]    pick;
    logic [NUM_REQ-1:0] rot;
    int                 idx;
    pick = ptr;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      rot = req >> idx;
      if (rot[0]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  assign winner = rr_pick(req_valid, ptr_reg);

`ifdef NVDLA_SSYNC_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic             tmo_err_reg, tmo_err_next;

  assign tmo_hit = (&tmo_reg) && (state_reg == REQ || state_reg == REL);

  always_comb begin
    tmo_next     = tmo_reg;
    tmo_err_next = tmo_err_reg | tmo_hit;
    if (state_reg == SETUP || (state_reg == REQ && ack_sync && !tmo_hit)) begin
      tmo_next = '0;
    end else if (state_reg == REQ || state_reg == REL) begin
      tmo_next = tmo_reg + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmo_reg     <= '0;
      tmo_err_reg <= 1'b0;
    end else begin
      tmo_reg     <= tmo_next;
      tmo_err_reg <= tmo_err_next;
    end
  end

  assign timeout_err = tmo_err_reg;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    id_next       = id_reg;
    sync_req_next = sync_req_reg;
    done_fire     = 1'b0;
    case (state_reg)
      IDLE: begin
        sync_req_next = 1'b0;
        if (|req_valid) begin
          id_next    = winner;
          ptr_next   = winner;
          state_next = SETUP;
        end
      end
      SETUP: begin
        sync_req_next = 1'b1;
        state_next    = REQ;
      end
      REQ: begin
        if (tmo_hit || ack_sync) begin
          sync_req_next = 1'b0;
          state_next    = tmo_hit ? IDLE : REL;
        end
      end
      REL: begin
        sync_req_next = 1'b0;
        if (tmo_hit) begin
          state_next = IDLE;
        end else if (!ack_sync) begin
          done_fire  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  // One-hot completion decode; sync_id is still the finished winner in that cycle.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_done
    assign done_next[gi] = done_fire && (id_reg == ID_W'(gi));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= ID_W'(NUM_REQ - 1);
      id_reg       <= '0;
      sync_req_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      id_reg       <= id_next;
      sync_req_reg <= sync_req_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign sync_id  = id_reg;
  assign sync_req = sync_req_reg;
  assign busy     = busy_reg;
  assign req_done = done_reg;

endmodule

// File: tb/tb_nvdla_ssync_req_arb.sv
// Directed bench for nvdla_ssync_req_arb: handshake timing, RR order, reset abort, timeout option.
`timescale 1ns/1ps
module tb_nvdla_ssync_req_arb;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
`ifdef NVDLA_SSYNC_ARB_TIMEOUT_EN
  localparam int TMO_W = 4;
`else
  localparam int TMO_W = 8;
`endif

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b1;
  logic [NUM_REQ-1:0] req_valid = '0;
  logic [NUM_REQ-1:0] req_done;
  logic [ID_W-1:0]    sync_id;
  logic               sync_req;
  logic               ack_sync = 1'b0;
  logic               busy;
  logic               timeout_err;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int bad_done = 0;
  int id_moves = 0;
  int exp_done = 0;
  logic            prev_busy = 1'b0;
  logic [ID_W-1:0] prev_id   = '0;

  always #5 i_clk = ~i_clk;

  nvdla_ssync_req_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TMO_W(TMO_W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .req_valid   (req_valid),
    .req_done    (req_done),
    .sync_id     (sync_id),
    .sync_req    (sync_req),
    .ack_sync    (ack_sync),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_rise(input string tag);
    int n;
    n = 0;
    while (sync_req !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check(tag, 32'(sync_req), 32'd1);
  endtask

  // Drive one handshake from the REQ phase to req_done; nxt is req_valid applied in the done cycle.
  task automatic hs(input int exp_id, input int ack_dly, input int rel_dly,
                    input logic [NUM_REQ-1:0] nxt);
    check("grant_id", 32'(sync_id), exp_id);
    repeat (ack_dly) tick;
    check("req_hold", 32'(sync_req), 32'd1);
    ack_sync = 1'b1;
    tick;
    check("req_fall", 32'(sync_req), 32'd0);
    repeat (rel_dly) tick;
    ack_sync = 1'b0;
    tick;
    check("done_pulse", 32'(req_done), 32'(1) << exp_id);
    check("busy_done", 32'(busy), 32'd0);
    $display("txn: id=%0d ack_dly=%0d rel_dly=%0d req_done=%b", exp_id, ack_dly, rel_dly, req_done);
    exp_done++;
    req_valid = nxt;
    tick;
    check("done_clr", 32'(req_done), 32'd0);
  endtask

  // sync_id must hold from SETUP through the req_done cycle; req_done must match it.
  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_busy <= 1'b0;
    end else begin
      if (req_done != '0) begin
        done_cnt <= done_cnt + 1;
        if (req_done != (NUM_REQ'(1) << sync_id)) bad_done <= bad_done + 1;
      end
      if (prev_busy && (busy || req_done != '0) && sync_id != prev_id) id_moves <= id_moves + 1;
      prev_busy <= busy;
      prev_id   <= sync_id;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick;
    check("rst_sync_req", 32'(sync_req), 32'd0);
    check("rst_sync_id", 32'(sync_id), 32'd0);
    check("rst_req_done", 32'(req_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    i_rst = 1'b0;
    tick;

    // First grant latency: SETUP next cycle, sync_req two cycles after the request
    req_valid = 4'b0001;
    tick;
    check("t1_setup_busy", 32'(busy), 32'd1);
    check("t1_setup_req", 32'(sync_req), 32'd0);
    check("t1_setup_id", 32'(sync_id), 32'd0);
    tick;
    check("t1_rise_t2", 32'(sync_req), 32'd1);
    hs(0, 3, 3, '0);
    tick;
    check("t1_idle_busy", 32'(busy), 32'd0);

    i_rst = 1'b1;
    tick;
    i_rst = 1'b0;
    tick;

    // All requesters held: 0,1,2,3,0
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      wait_rise("rr_rise");
      hs(k % 4, k % 3, (k == 4) ? 0 : 1, (k == 4) ? 4'b0000 : 4'b1111);
    end

    // Request dropped after grant still completes
    req_valid = 4'b0100;
    wait_rise("drop_rise");
    req_valid = '0;
    hs(2, 2, 1, '0);

    // Single requester re-granted
    req_valid = 4'b0010;
    wait_rise("single_rise1");
    hs(1, 1, 1, 4'b0010);
    wait_rise("single_rise2");
    hs(1, 0, 0, '0);

    // ack_sync high in IDLE and SETUP is ignored
    ack_sync = 1'b1;
    repeat (3) tick;
    check("ack_idle_busy", 32'(busy), 32'd0);
    check("ack_idle_req", 32'(sync_req), 32'd0);
    req_valid = 4'b1000;
    tick;
    check("ack_setup_busy", 32'(busy), 32'd1);
    check("ack_setup_req", 32'(sync_req), 32'd0);
    check("ack_setup_id", 32'(sync_id), 32'd3);
    tick;
    check("ack_setup_rise", 32'(sync_req), 32'd1);
    hs(3, 0, 1, '0);

    // Reset mid-REQ drops sync_req without a clock edge
    req_valid = 4'b0001;
    wait_rise("rstreq_rise");
    req_valid = '0;
    #2 i_rst = 1'b1;
    #1;
    check("rstreq_async_req", 32'(sync_req), 32'd0);
    check("rstreq_async_busy", 32'(busy), 32'd0);
    tick;
    i_rst = 1'b0;
    tick;

    // Reset in REL with ack high, then requester 0 wins first
    req_valid = 4'b0100;
    wait_rise("rstrel_rise");
    check("rstrel_id", 32'(sync_id), 32'd2);
    ack_sync = 1'b1;
    tick;
    check("rstrel_in_rel", 32'(sync_req), 32'd0);
    req_valid = '0;
    #2 i_rst = 1'b1;
    #1;
    check("rstrel_busy", 32'(busy), 32'd0);
    check("rstrel_id0", 32'(sync_id), 32'd0);
    check("rstrel_req", 32'(sync_req), 32'd0);
    check("rstrel_done", 32'(req_done), 32'd0);
    ack_sync = 1'b0;
    tick;
    i_rst = 1'b0;
    tick;
    req_valid = '1;
    wait_rise("post_rst_rise");
    hs(0, 1, 1, '0);

    // ack never returns
    req_valid = 4'b0010;
    wait_rise("tmo_rise");
    req_valid = '0;
    repeat (8) tick;
    check("tmo_not_early", 32'(sync_req), 32'd1);
    repeat (12) tick;
`ifdef NVDLA_SSYNC_ARB_TIMEOUT_EN
    check("tmo_err_set", 32'(timeout_err), 32'd1);
    check("tmo_req_drop", 32'(sync_req), 32'd0);
    check("tmo_idle", 32'(busy), 32'd0);
    req_valid = 4'b0001;
    wait_rise("tmo_next_rise");
    hs(0, 1, 1, '0);
    check("tmo_sticky", 32'(timeout_err), 32'd1);
`else
    check("notmo_err", 32'(timeout_err), 32'd0);
    check("notmo_req_held", 32'(sync_req), 32'd1);
    check("notmo_busy", 32'(busy), 32'd1);
    hs(1, 0, 0, '0);
`endif

    repeat (2) tick;
    check("id_stable", id_moves, 32'd0);
    check("done_onehot", bad_done, 32'd0);
    check("done_count", done_cnt, exp_done);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
